// File: rtl/signal_checker.sv
// Receive-side checker: realigns the reference stream by LAG accepted samples and compares
// each sample under test against it within TOL, accumulating a verdict and error statistics.
module signal_checker #(
  parameter int LAG         = 4,
  parameter int NUM_SAMPLES = 1024,
  parameter int TOL         = 0,
  parameter int CNT_W       = 16
) (
  input  logic                    clk_samplying,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    sample_en,
  input  logic signed [15:0]      ref_in,
  input  logic signed [15:0]      dut_in,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [CNT_W-1:0]        err_count,
  output logic [CNT_W-1:0]        first_err_idx,
  output logic [16:0]             max_abs_err,
  output logic [1:0]              state_dbg
);

  // Handshake: a sample is consumed on any rising edge where sample_en=1 while busy; there is
  // no backpressure, so sample_en low simply stalls the run for as long as it stays low.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int          FILL_W = (LAG > 1) ? $clog2(LAG) : 1;
  localparam int          CHK_W  = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam logic [16:0] TOL_V  = 17'(TOL);

  state_t             state, state_nx;
  logic [FILL_W-1:0]  fill_cnt;
  logic [CHK_W-1:0]   chk_cnt;
  logic               launch, accept, compare;
  logic signed [15:0] ref_d;
  logic [16:0]        diff, abs_diff;
  logic               mismatch;

  assign launch  = start && (state == S_IDLE || state == S_DONE);
  assign accept  = sample_en && (state == S_FILL || state == S_CHECK);
  assign compare = accept && (state == S_CHECK);

  generate
    if (LAG > 0) begin : g_dly
      logic signed [15:0] dly [LAG];

      always_ff @(posedge clk_samplying or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < LAG; i++) dly[i] <= '0;
        end else if (accept) begin
          dly[0] <= ref_in;
          for (int i = 1; i < LAG; i++) dly[i] <= dly[i-1];
        end
      end

      assign ref_d = dly[LAG-1];
    end else begin : g_nodly
      assign ref_d = ref_in;
    end
  endgenerate

  // 17-bit difference cannot overflow; magnitude of -65536 still fits as unsigned 17'h10000.
  assign diff     = {dut_in[15], dut_in} - {ref_d[15], ref_d};
  assign abs_diff = diff[16] ? (~diff + 17'd1) : diff;
  assign mismatch = abs_diff > TOL_V;

  always_ff @(posedge clk_samplying or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = (LAG > 0) ? S_FILL : S_CHECK;
      S_FILL:         if (accept && fill_cnt == FILL_W'(LAG - 1)) state_nx = S_CHECK;
      S_CHECK:        if (accept && chk_cnt == CHK_W'(NUM_SAMPLES - 1)) state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_samplying or posedge rst) begin
    if (rst) begin
      fill_cnt      <= '0;
      chk_cnt       <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      max_abs_err   <= '0;
    end else if (launch) begin
      fill_cnt      <= '0;
      chk_cnt       <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      max_abs_err   <= '0;
    end else if (accept && state == S_FILL) begin
      fill_cnt <= fill_cnt + 1'b1;
    end else if (compare) begin
      chk_cnt <= chk_cnt + 1'b1;
      if (abs_diff > max_abs_err) max_abs_err <= abs_diff;
      if (mismatch) begin
        // err_count is still zero only until the first mismatch has been recorded.
        if (err_count == '0) first_err_idx <= CNT_W'(chk_cnt);
        if (err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end

  assign busy      = (state == S_FILL) || (state == S_CHECK);
  assign done      = (state == S_DONE);
  assign pass      = done && (err_count == '0);
  assign state_dbg = state;

endmodule

// File: tb/tb_signal_checker.sv
// Randomized bench for signal_checker: three instances share one stimulus stream and are
// scored against a run-level reference model that works on whole lists of accepted samples.
module tb_signal_checker;

  localparam int N_ACC = 20;

  logic        clk_samplying = 1'b0;
  logic        rst, start, sample_en;
  logic [15:0] ref_in, dut_in;

  logic        a_busy, a_done, a_pass, b_busy, b_done, b_pass, c_busy, c_done, c_pass;
  logic [15:0] a_err, a_first, b_err, b_first;
  logic [3:0]  c_err, c_first;
  logic [16:0] a_mx, b_mx, c_mx;
  logic [1:0]  a_state, b_state, c_state;

  always #5 clk_samplying = ~clk_samplying;

  signal_checker #(.LAG(4), .NUM_SAMPLES(16), .TOL(2), .CNT_W(16)) u_a (
    .clk_samplying(clk_samplying), .rst(rst), .start(start), .sample_en(sample_en),
    .ref_in(ref_in), .dut_in(dut_in), .busy(a_busy), .done(a_done), .pass(a_pass),
    .err_count(a_err), .first_err_idx(a_first), .max_abs_err(a_mx), .state_dbg(a_state));

  signal_checker #(.LAG(4), .NUM_SAMPLES(16), .TOL(3), .CNT_W(16)) u_b (
    .clk_samplying(clk_samplying), .rst(rst), .start(start), .sample_en(sample_en),
    .ref_in(ref_in), .dut_in(dut_in), .busy(b_busy), .done(b_done), .pass(b_pass),
    .err_count(b_err), .first_err_idx(b_first), .max_abs_err(b_mx), .state_dbg(b_state));

  signal_checker #(.LAG(0), .NUM_SAMPLES(20), .TOL(0), .CNT_W(4)) u_c (
    .clk_samplying(clk_samplying), .rst(rst), .start(start), .sample_en(sample_en),
    .ref_in(ref_in), .dut_in(dut_in), .busy(c_busy), .done(c_done), .pass(c_pass),
    .err_count(c_err), .first_err_idx(c_first), .max_abs_err(c_mx), .state_dbg(c_state));

  typedef struct packed {
    logic        pass;
    logic [15:0] err;
    logic [15:0] first;
    logic [16:0] mx;
  } res_t;

  res_t exp_q_a[$], exp_q_b[$], exp_q_c[$];
  logic signed [15:0] ref_s [N_ACC];
  logic signed [15:0] dut_s [N_ACC];
  int   checks = 0, failures = 0;
  logic track_c = 1'b0, fill_seen_c = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Run verdict straight from the rule: compared sample i pairs dut[lag+i] with ref[i].
  function automatic res_t model(int lag, int ns, int tol, int cntw);
    res_t r;
    int errs = 0, first = -1, mx = 0, d;
    for (int i = 0; i < ns; i++) begin
      d = int'(dut_s[lag+i]) - int'(ref_s[i]);
      if (d < 0) d = -d;
      if (d > mx) mx = d;
      if (d > tol) begin
        if (first < 0) first = i;
        errs++;
      end
    end
    if (errs > (1 << cntw) - 1) errs = (1 << cntw) - 1;
    r.pass  = (errs == 0);
    r.err   = 16'(errs);
    r.first = (first < 0) ? 16'd0 : 16'(first & ((1 << cntw) - 1));
    r.mx    = 17'(mx);
    return r;
  endfunction

  task automatic gen(input int mode);
    for (int k = 0; k < N_ACC; k++) ref_s[k] = 16'($urandom_range(0, 65535));
    if (mode == 1) ref_s[5] = 16'($urandom_range(0, 1000));
    for (int k = 0; k < N_ACC; k++) begin
      case (mode)
        0, 1: dut_s[k] = (k >= 4) ? ref_s[k-4] : 16'($urandom_range(0, 65535));
        2: begin
          ref_s[k] = 16'h8000;
          dut_s[k] = 16'h7FFF;
        end
        3: begin
          if (k < 4 || $urandom_range(0, 5) == 0) dut_s[k] = 16'($urandom_range(0, 65535));
          else dut_s[k] = ref_s[k-4] + 16'($urandom_range(0, 8)) - 16'd4;
        end
        default: dut_s[k] = ref_s[k];
      endcase
    end
    if (mode == 1) dut_s[9] = ref_s[5] + 16'sd3;
  endtask

  task automatic push_exp();
    exp_q_a.push_back(model(4, 16, 2, 16));
    exp_q_b.push_back(model(4, 16, 3, 16));
    exp_q_c.push_back(model(0, 20, 0, 4));
  endtask

  task automatic drive_start();
    @(negedge clk_samplying);
    start     = 1'b1;
    sample_en = 1'($urandom_range(0, 1));
    ref_in    = 16'($urandom);
    dut_in    = 16'($urandom);
    @(negedge clk_samplying);
    start     = 1'b0;
    sample_en = 1'b0;
    check("start_busy_a", a_busy, 1);
    check("start_clr_err_a", a_err, 0);
    check("start_clr_done_a", a_done, 0);
    check("start_busy_c", c_busy, 1);
  endtask

  task automatic drive_samples(input int from, input int upto, input bit pulse);
    for (int k = from; k < upto; k++) begin
      repeat ($urandom_range(0, 2)) begin
        sample_en = 1'b0;
        ref_in    = 16'($urandom);
        dut_in    = 16'($urandom);
        start     = pulse && k < 3 && ($urandom_range(0, 1) == 1);
        @(negedge clk_samplying);
      end
      if (k == N_ACC - 1) begin
        check("done_early_a", a_done, 0);
        check("done_early_c", c_done, 0);
      end
      sample_en = 1'b1;
      ref_in    = ref_s[k];
      dut_in    = dut_s[k];
      start     = pulse && k < 3 && ($urandom_range(0, 1) == 1);
      @(negedge clk_samplying);
    end
    sample_en = 1'b0;
    start     = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!a_done && n < 4) begin
      @(negedge clk_samplying);
      n++;
    end
    check("done_latency", n, 0);
    repeat (2) @(negedge clk_samplying);
  endtask

  task automatic full_run(input int mode, input bit pulse);
    gen(mode);
    push_exp();
    drive_start();
    drive_samples(0, N_ACC, pulse);
    wait_done();
  endtask

  task automatic reset_mid_check();
    gen(2);
    drive_start();
    drive_samples(0, 10, 1'b0);
    check("running_err_a", a_err, 6);
    check("running_err_c", c_err, 10);
    #2 rst = 1'b1;
    #1;
    check("rst_busy_a", a_busy, 0);
    check("rst_err_a", a_err, 0);
    check("rst_first_a", a_first, 0);
    check("rst_max_a", a_mx, 0);
    check("rst_busy_c", c_busy, 0);
    check("rst_err_c", c_err, 0);
    check("rst_max_c", c_mx, 0);
    check("rst_done_b", b_done, 0);
    @(negedge clk_samplying);
    rst = 1'b0;
  endtask

  // Monitor: each rising edge of done retires one expected verdict per instance.
  initial begin
    logic done_q = 1'b0;
    res_t ea, eb, ec;
    forever begin
      @(negedge clk_samplying);
      if (track_c && c_state == 2'd1) fill_seen_c = 1'b1;
      if (!rst && a_done && !done_q) begin
        if (exp_q_a.size() == 0 || exp_q_b.size() == 0 || exp_q_c.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          ea = exp_q_a.pop_front();
          eb = exp_q_b.pop_front();
          ec = exp_q_c.pop_front();
          check("a_pass", a_pass, ea.pass);
          check("a_err", a_err, ea.err);
          check("a_first", a_first, ea.first);
          check("a_max", a_mx, ea.mx);
          check("b_done", b_done, 1);
          check("b_pass", b_pass, eb.pass);
          check("b_err", b_err, eb.err);
          check("b_first", b_first, eb.first);
          check("b_max", b_mx, eb.mx);
          check("c_done", c_done, 1);
          check("c_pass", c_pass, ec.pass);
          check("c_err", {12'd0, c_err}, ec.err);
          check("c_first", {12'd0, c_first}, ec.first);
          check("c_max", c_mx, ec.mx);
        end
      end
      done_q = a_done;
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; sample_en = 1'b0; ref_in = '0; dut_in = '0;
    repeat (2) @(negedge clk_samplying);
    check("reset_busy", a_busy, 0);
    check("reset_done", a_done, 0);
    check("reset_pass", a_pass, 0);
    check("reset_err", a_err, 0);
    check("reset_first", a_first, 0);
    check("reset_max", a_mx, 0);
    check("reset_state_c", c_state, 0);
    rst = 1'b0;

    full_run(0, 1'b0);
    full_run(1, 1'b1);
    full_run(2, 1'b0);
    for (int r = 0; r < 3; r++) full_run(3, 1'b1);
    reset_mid_check();
    full_run(3, 1'b0);
    track_c = 1'b1;
    full_run(4, 1'b1);
    track_c = 1'b0;

    check("no_fill_lag0", fill_seen_c, 0);
    check("exp_q_drained", exp_q_a.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
